// File: rtl/viterbi_tb_ctrl.sv
// Viterbi traceback controller: circular survivor memory plus a per-symbol traceback
// of TB_LEN steps that hands one decoded bit downstream over a valid/ready handshake.
module viterbi_tb_ctrl #(
    parameter int K      = 3,
    parameter int TB_LEN = 15,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16,
    localparam int M     = K - 1,
    localparam int NS    = 1 << M
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [NS-1:0]    sym_dec,
    input  logic [M-1:0]     sym_best,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_out,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(TB_LEN + 1);
    localparam logic [SW-1:0] TB_LEN_C = SW'(TB_LEN);

    typedef enum logic [1:0] {IDLE, TRACE, OUT} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    tb_col_q, tb_col_d;
    logic [SW-1:0]    fill_q, fill_d;
    logic [SW-1:0]    step_q, step_d;
    logic [M-1:0]     tb_state_q, tb_state_d;
    logic             bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NS-1:0]    mem_q [DEPTH];
    logic             accept;
    logic             trace_dec;
    logic [M-1:0]     tb_prev;

    assign accept    = sym_valid && sym_ready;
    assign trace_dec = mem_q[tb_col_q][tb_state_q];
    // Predecessor of the current traceback state, selected by its stored survivor bit.
    assign tb_prev   = {tb_state_q[M-2:0], trace_dec};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept && fill_q == TB_LEN_C) state_d = TRACE;
                TRACE:   if (step_q == SW'(1)) state_d = OUT;
                OUT:     if (bit_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // clear also withdraws sym_ready so a vector presented alongside it is not taken.
    always_comb begin
        sym_ready = (state_q == IDLE) && !clear;
        bit_valid = (state_q == OUT);
        busy      = (state_q != IDLE);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        tb_col_d   = tb_col_q;
        fill_d     = fill_q;
        step_d     = step_q;
        tb_state_d = tb_state_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        if (clear) begin
            wr_ptr_d = '0;
            fill_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        tb_col_d   = wr_ptr_q;
                        tb_state_d = sym_best;
                        wr_ptr_d   = wr_ptr_q + 1'b1;
                        if (fill_q < TB_LEN_C) fill_d = fill_q + 1'b1;
                        else                   step_d = TB_LEN_C;
                    end
                end
                TRACE: begin
                    tb_state_d = tb_prev;
                    tb_col_d   = tb_col_q - 1'b1;
                    step_d     = step_q - 1'b1;
                    if (step_q == SW'(1)) bit_d = tb_prev[M-1];
                end
                OUT: begin
                    if (bit_ready) cnt_d = cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            tb_col_q   <= '0;
            fill_q     <= '0;
            step_q     <= '0;
            tb_state_q <= '0;
            bit_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            tb_col_q   <= tb_col_d;
            fill_q     <= fill_d;
            step_q     <= step_d;
            tb_state_q <= tb_state_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
        end
    end

    // Survivor storage is never read before written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= sym_dec;
    end

    assign bit_out   = bit_q;
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_viterbi_tb_ctrl.sv
// Bench for viterbi_tb_ctrl: drives decision vectors of a known encoder path and checks
// every cycle against a model that emits the input bit TB_LEN symbols back.
module tb_viterbi_tb_ctrl;

    localparam int K      = 3;
    localparam int TB_LEN = 15;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;
    localparam int M      = K - 1;
    localparam int NS     = 1 << M;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             sym_valid = 1'b0;
    logic             sym_ready;
    logic [NS-1:0]    sym_dec = '0;
    logic [M-1:0]     sym_best = '0;
    logic             bit_valid;
    logic             bit_ready = 1'b1;
    logic             bit_out;
    logic             busy;
    logic [CNT_W-1:0] bit_count;

    viterbi_tb_ctrl #(.K(K), .TB_LEN(TB_LEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_dec(sym_dec), .sym_best(sym_best),
        .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_out(bit_out),
        .busy(busy), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Encoder-side path state and the input bit carried by the vector on the bus
    logic [M-1:0] ps = '0;
    bit           cur_in = 1'b0;
    bit           got[$];

    // Reference model: counts of cycles, accepted inputs, expected emitted bit
    int m_trace = 0;
    bit m_out = 1'b0;
    bit m_bit = 1'b0;
    int m_cnt = 0;
    int m_nacc = 0;
    bit m_hist[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_trace = 0; m_out = 1'b0; m_cnt = 0; m_nacc = 0; m_hist.delete();
        end
        chk("bit_valid", 32'(bit_valid), 32'(m_out));
        chk("busy", 32'(busy), 32'((m_trace > 0) || m_out));
        if (!clear) chk("sym_ready", 32'(sym_ready), 32'((m_trace == 0) && !m_out));
        chk("bit_count", 32'(bit_count), 32'(m_cnt));
        if (m_out) chk("bit_out", 32'(bit_out), 32'(m_bit));
        if (rst_n && bit_valid && bit_ready && !clear) got.push_back(bit_out);
        if (rst_n) begin
            if (clear) begin
                m_trace = 0; m_out = 1'b0; m_nacc = 0; m_hist.delete();
            end else if (m_trace == 0 && !m_out) begin
                if (sym_valid) begin
                    m_hist.push_back(cur_in);
                    m_nacc++;
                    if (m_nacc > TB_LEN) begin
                        m_trace = TB_LEN;
                        m_bit   = m_hist[m_nacc - 1 - TB_LEN];
                    end
                end
            end else if (m_trace > 0) begin
                m_trace--;
                if (m_trace == 0) m_out = 1'b1;
            end else if (bit_ready) begin
                m_out = 1'b0;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
        end
    end

    // Present one symbol of the encoder path; off-path survivor bits random or zero.
    task automatic send_vec(input bit in, input bit rnd_off);
        logic [M-1:0]  ns;
        logic [NS-1:0] dec;
        bit            acc;
        ns  = {in, ps[M-1:1]};
        dec = rnd_off ? NS'($urandom) : '0;
        dec[ns] = ps[0];
        sym_dec = dec; sym_best = ns; cur_in = in; sym_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = sym_ready && !clear && rst_n;
            @(posedge clk); #1;
        end
        sym_valid = 1'b0;
        if (!acc) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: vector not taken within 200 cycles");
        end
        ps = ns;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [23:0] pat = 24'b1011_0011_1010_0101_1100_0111;
    logic [8:0]  exp9 = 9'b101100111;
    bit          ok;
    int          base;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sym_ready", 32'(sym_ready), 32'd1);
        chk("rst_bit_valid", 32'(bit_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bit_count", 32'(bit_count), 32'd0);
        rst_n = 1'b1;
        wait_cyc(1);

        // All-zero decisions, 20 vectors back-to-back
        got.delete();
        for (int i = 0; i < 20; i++) send_vec(1'b0, 1'b0);
        wait_cyc(20);
        chk("zero_nbits", 32'(got.size()), 32'd5);
        for (int i = 0; i < got.size(); i++) chk("zero_bit", 32'(got[i]), 32'd0);
        chk("zero_count", 32'(bit_count), 32'd5);

        // Known input pattern, MSB first
        do_clear();
        chk("clear_keeps_count", 32'(bit_count), 32'd5);
        got.delete();
        for (int i = 0; i < 24; i++) send_vec(pat[23 - i], 1'b1);
        wait_cyc(20);
        chk("pat_nbits", 32'(got.size()), 32'd9);
        for (int i = 0; i < 9 && i < got.size(); i++) chk("pat_bit", 32'(got[i]), 32'(exp9[8 - i]));

        // Backpressure: bit_ready low while the first bit sits in OUT
        do_clear();
        got.delete();
        bit_ready = 1'b0;
        send_vec(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) send_vec(1'($urandom_range(0, 1)), 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = bit_valid;
        end
        chk("hold_reached", 32'(ok), 32'd1);
        repeat (10) begin
            @(negedge clk);
            chk("hold_valid", 32'(bit_valid), 32'd1);
            chk("hold_bit", 32'(bit_out), 32'd1);
            chk("hold_ready", 32'(sym_ready), 32'd0);
        end
        @(posedge clk); #1;
        bit_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_valid", 32'(bit_valid), 32'd0);
        chk("release_ready", 32'(sym_ready), 32'd1);
        chk("release_nbits", 32'(got.size()), 32'd1);
        #1;

        // Random path long enough to wrap the write pointer twice
        @(posedge clk); #1;
        do_clear();
        got.delete();
        for (int i = 0; i < 40; i++) send_vec(1'($urandom_range(0, 1)), 1'b1);
        wait_cyc(20);
        chk("rand_nbits", 32'(got.size()), 32'd25);

        // clear in the middle of a traceback
        do_clear();
        got.delete();
        for (int i = 0; i < 16; i++) send_vec(1'($urandom_range(0, 1)), 1'b1);
        repeat (8) @(posedge clk);
        #1;
        do_clear();
        wait_cyc(20);
        chk("midclear_nbits", 32'(got.size()), 32'd0);
        for (int i = 0; i < 15; i++) send_vec(1'($urandom_range(0, 1)), 1'b1);
        wait_cyc(5);
        chk("refill_nbits", 32'(got.size()), 32'd0);
        send_vec(1'($urandom_range(0, 1)), 1'b1);
        wait_cyc(20);
        chk("refill_done", 32'(got.size()), 32'd1);

        // Asynchronous reset during a traceback
        do_clear();
        for (int i = 0; i < 16; i++) send_vec(1'($urandom_range(0, 1)), 1'b1);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_sym_ready", 32'(sym_ready), 32'd1);
        chk("async_bit_valid", 32'(bit_valid), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_bit_count", 32'(bit_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        base = 0;
        for (int i = 0; i < 16; i++) send_vec(1'($urandom_range(0, 1)), 1'b1);
        wait_cyc(20);
        chk("post_reset_nbits", 32'(got.size()), 32'(base + 1));
        chk("post_reset_count", 32'(bit_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
